clk_period_meter: RTL and testbench
===================================

// Module: clk_period_meter
// PURPOSE
//  Measures the period of a slow external clock or toggle (e.g. a divided clock)
//  in cycles of the local clock clk_in. It is the receiving end of a divided-clock
//  link and is used to check divider output and board clocks.
//  sig_in is asynchronous to clk_in. It is synchronised, rising-edge detected and
//  timed, and one period result is published per detected rising edge.
// PARAMETERS
//  CNT_WIDTH   32         width of period counter and results
//  TIMEOUT     250000000  cycles with no rising edge before timeout; 1 < TIMEOUT < 2**CNT_WIDTH
//  SYNC_STAGES 2          flops in the sig_in synchroniser; must be >= 2
// PORTS
//  clk_in        input   1          measurement clock
//  resetn        input   1          asynchronous, active-low reset
//  sig_in        input   1          signal under test, asynchronous to clk_in
//  period_out    output  CNT_WIDTH  last measured period, in clk_in cycles
//  period_valid  output  1          one-cycle pulse: period_out updated this cycle
//  timeout       output  1          level: no rising edge within TIMEOUT cycles
//  locked        output  1          level: at least one full period measured, no timeout since
// BEHAVIOUR
//  - Reset (async assert, sync release): sync chain, edge flop, cnt, period_out,
//    period_valid, timeout and locked all go to 0. State goes to IDLE.
//  - Sync chain: SYNC_STAGES flops on sig_in, plus one prev flop.
//    rise = sync & ~prev. rise is seen SYNC_STAGES+1 clk_in cycles after sig_in rises.
//  - cnt: CNT_WIDTH bits. Increments every cycle without rise, saturating at all-ones.
//  - FSM states: IDLE, ARMED, MEAS.
//    IDLE:  cnt is held at 0. On rise: cnt<=1, go to ARMED, timeout<=0.
//    ARMED: on rise: period_out<=cnt, period_valid<=1, cnt<=1, locked<=1, go to MEAS.
//    MEAS:  on rise: same update as ARMED, stay in MEAS.
//    ARMED/MEAS, no rise, cnt==TIMEOUT: timeout<=1, locked<=0, cnt<=0, go to IDLE.
//      period_out holds its last value.
//  - Result: a rise every P cycles gives period_out=P. period_valid is registered,
//    so it asserts the cycle after the rise is seen.
//  - Rise and cnt==TIMEOUT in the same cycle: rise wins, no timeout.
//  - The first rise after reset or after a timeout only arms the FSM. No
//    period_valid is produced until the second rise.
//  - period_valid is never asserted two cycles in a row. The minimum measurable
//    period is 2 cycles; faster inputs alias.
//  - Reset asserted mid-measurement: outputs clear immediately, the partial period
//    is discarded, and the next rise only arms.
// CONFIGURATION
//  PERIOD_METER_DUTY_EN defined:
//  - Extra output high_out (CNT_WIDTH bits), reset value 0.
//  - Fall detect: fall = ~sync & prev.
//  - On a fall in ARMED/MEAS, the current cnt is latched into high_pend. This is
//    the high time, in cycles, since the last rise.
//  - On each period_valid, high_out<=high_pend.
//  - On timeout, high_out holds its value.
//  PERIOD_METER_DUTY_EN undefined:
//  - No high_out port, no fall detect, no high_pend register.
// TESTING
//  1. Assert resetn=0 mid-cycle -> all outputs 0 immediately (async). Release -> outputs stay 0.
//  2. sig_in square wave, 5 high / 5 low -> first rise gives no valid. Then
//     period_valid every 10 cycles with period_out=10, locked=1 after the 2nd rise.
//  3. Change the period from 10 to 16 cycles -> from the 2nd valid after the change,
//     period_out=16 with no missed pulses.
//  4. TIMEOUT=100, stop sig_in low after a rise -> timeout=1 and locked=0 on the
//     cycle after cnt reaches 100. period_out holds 10. The next rise clears timeout
//     and only arms.
//  5. Pulse resetn low between two rises -> next rise gives no period_valid;
//     the following rise gives the correct period.
//  6. PERIOD_METER_DUTY_EN, 3 high / 7 low -> period_out=10, high_out=3 on every valid.

Source files
------------

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the period of a slow signal (typically a divided clock) in cycles of
// the local clock clk_in. sig_in is asynchronous: it passes through a
// synchroniser, then a rising-edge detector. One period result is published per
// detected rising edge, after the first edge has armed the meter.
//
// Optional feature (compile-time macro PERIOD_METER_DUTY_EN):
//   adds the high_out port, which reports the high time of the last measured
//   period, in clk_in cycles.
//
// Parameters
//   CNT_WIDTH    width of the period counter and of the results
//   TIMEOUT      cycles without a rising edge before timeout (1 < TIMEOUT < 2**CNT_WIDTH)
//   SYNC_STAGES  flops in the sig_in synchroniser (>= 2)
//
// Ports
//   clk_in        in   1          measurement clock
//   resetn        in   1          asynchronous active-low reset
//   sig_in        in   1          signal under test, asynchronous to clk_in
//   period_out    out  CNT_WIDTH  last measured period, in clk_in cycles
//   period_valid  out  1          one-cycle pulse when period_out is updated
//   timeout       out  1          level: no rising edge within TIMEOUT cycles
//   locked        out  1          level: a full period measured, no timeout since
//   high_out      out  CNT_WIDTH  (PERIOD_METER_DUTY_EN only) high time of last period
// -----------------------------------------------------------------------------
module clk_period_meter #(
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned TIMEOUT     = 250000000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk_in,
   input  logic                 resetn,
   input  logic                 sig_in,
   output logic [CNT_WIDTH-1:0] period_out,
   output logic                 period_valid,
   output logic                 timeout,
   output logic                 locked
`ifdef PERIOD_METER_DUTY_EN
   ,
   output logic [CNT_WIDTH-1:0] high_out
`endif
);

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StMeas
   } state_e;

   // --------------------------------------------------------------------------
   // Synchroniser and edge detection
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sig_sync;
   logic                   rise;

   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sig_sync;
      end
   end

   assign sig_sync = sync_q[SYNC_STAGES-1];
   assign rise     = sig_sync & ~prev_q;

`ifdef PERIOD_METER_DUTY_EN
   logic fall;
   assign fall = ~sig_sync & prev_q;
`endif

   // --------------------------------------------------------------------------
   // Period counter increment, saturating at all-ones
   // --------------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_inc;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // --------------------------------------------------------------------------
   // Measurement FSM with registered outputs
   // --------------------------------------------------------------------------
   state_e state_q;

`ifdef PERIOD_METER_DUTY_EN
   logic [CNT_WIDTH-1:0] high_pend_q;
`endif

   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         period_out   <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         locked       <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
         high_pend_q  <= '0;
         high_out     <= '0;
`endif
      end else begin
         period_valid <= 1'b0;
         case (state_q)
            StIdle: begin
               // The first edge only starts the count; no result yet.
               if (rise) begin
                  cnt_q   <= CNT_ONE;
                  timeout <= 1'b0;
                  state_q <= StArmed;
               end else begin
                  cnt_q <= '0;
               end
            end

            StArmed, StMeas: begin
               // A rise arriving exactly when cnt hits TIMEOUT still counts as
               // a valid period, so rise is tested before the timeout.
               if (rise) begin
                  period_out   <= cnt_q;
                  period_valid <= 1'b1;
                  cnt_q        <= CNT_ONE;
                  locked       <= 1'b1;
                  state_q      <= StMeas;
`ifdef PERIOD_METER_DUTY_EN
                  high_out     <= high_pend_q;
`endif
               end else if (cnt_q == TIMEOUT_CNT) begin
                  timeout <= 1'b1;
                  locked  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_inc;
               end
`ifdef PERIOD_METER_DUTY_EN
               // cnt counts cycles since the last rise, so at the fall it is the
               // high time of the current period.
               if (fall) begin
                  high_pend_q <= cnt_q;
               end
`endif
            end

            default: begin
               cnt_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

   localparam int unsigned CW  = 32;
   localparam int unsigned TO  = 100;
   localparam int unsigned SS  = 2;

   logic          clk_in = 1'b0;
   logic          resetn = 1'b0;
   logic          sig_in = 1'b0;
   logic [CW-1:0] period_out;
   logic          period_valid;
   logic          timeout;
   logic          locked;
`ifdef PERIOD_METER_DUTY_EN
   logic [CW-1:0] high_out;
`endif

   clk_period_meter #(
      .CNT_WIDTH   (CW),
      .TIMEOUT     (TO),
      .SYNC_STAGES (SS)
   ) dut (
      .clk_in       (clk_in),
      .resetn       (resetn),
      .sig_in       (sig_in),
      .period_out   (period_out),
      .period_valid (period_valid),
      .timeout      (timeout),
      .locked       (locked)
`ifdef PERIOD_METER_DUTY_EN
      ,
      .high_out     (high_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // --------------------------------------------------------------------------
   // Reference model: works on edge times. Sample k of sig_in reaches the edge
   // detector SS+1 edges later; a period is the distance between two detected
   // rises; timeout fires TIMEOUT edges after the last rise.
   // --------------------------------------------------------------------------
   bit          hist [0:SS+1];
   int          e_idx;
   int          last_rise;
   int          last_fall_len;
   bit          armed;
   logic [CW-1:0] exp_period;
   logic [CW-1:0] exp_high;
   bit          exp_valid, exp_timeout, exp_locked;

   initial begin
      forever begin
         @(posedge clk_in or negedge resetn);
         if (!resetn) begin
            for (int i = 0; i <= SS + 1; i++) hist[i] = 1'b0;
            armed = 0; exp_period = '0; exp_high = '0; last_fall_len = 0;
            exp_valid = 0; exp_timeout = 0; exp_locked = 0; last_rise = 0;
         end else begin
            bit r, f;
            e_idx++;
            for (int i = SS + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sig_in;
            r = hist[SS] & ~hist[SS+1];
            f = ~hist[SS] & hist[SS+1];
            exp_valid = 0;
            if (f && armed) last_fall_len = e_idx - last_rise;
            if (r) begin
               if (armed) begin
                  exp_period = CW'(e_idx - last_rise);
                  exp_high   = CW'(last_fall_len);
                  exp_valid  = 1;
                  exp_locked = 1;
               end else begin
                  armed       = 1;
                  exp_timeout = 0;
               end
               last_rise = e_idx;
            end else if (armed && (e_idx - last_rise) == int'(TO)) begin
               exp_timeout = 1;
               exp_locked  = 0;
               armed       = 0;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Compare process, plus a record of observed results for literal pins
   // --------------------------------------------------------------------------
   int            valid_cnt = 0;
   logic [CW-1:0] seen_period = '0;
   logic [CW-1:0] seen_high = '0;

   initial begin
      forever begin
         @(negedge clk_in);
         if (resetn) begin
            check("period_valid", 64'(period_valid), 64'(exp_valid));
            check("period_out",   64'(period_out),   64'(exp_period));
            check("timeout",      64'(timeout),      64'(exp_timeout));
            check("locked",       64'(locked),       64'(exp_locked));
`ifdef PERIOD_METER_DUTY_EN
            check("high_out",     64'(high_out),     64'(exp_high));
`endif
            if (period_valid) begin
               valid_cnt++;
               seen_period = period_out;
`ifdef PERIOD_METER_DUTY_EN
               seen_high = high_out;
`endif
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   task automatic drive_wave(input int h, input int l, input int n);
      for (int k = 0; k < n; k++) begin
         sig_in = 1'b1;
         repeat (h) tick();
         sig_in = 1'b0;
         repeat (l) tick();
      end
   endtask

   task automatic pin_zero(input string tag);
      check({tag, "_period_out"},   64'(period_out),   64'd0);
      check({tag, "_period_valid"}, 64'(period_valid), 64'd0);
      check({tag, "_timeout"},      64'(timeout),      64'd0);
      check({tag, "_locked"},       64'(locked),       64'd0);
   endtask

   task automatic reset_pulse();
      #2 resetn = 1'b0;
      #1 pin_zero("async_rst");
      tick();
      resetn = 1'b1;
   endtask

   int v0;

   initial begin
      e_idx = 0;
      resetn = 1'b0;
      sig_in = 1'b0;
      repeat (3) tick();
      pin_zero("in_reset");
      resetn = 1'b1;
      repeat (3) tick();
      pin_zero("after_release");

      // 5 high / 5 low: first rise arms, then a result every 10 cycles
      v0 = valid_cnt;
      drive_wave(5, 5, 6);
      repeat (8) tick();
      check("sq10_valids", 64'(valid_cnt - v0), 64'd5);
      check("sq10_period", 64'(seen_period), 64'd10);
      check("sq10_locked", 64'(locked), 64'd1);

      // Period change 10 -> 16, no missed pulses
      v0 = valid_cnt;
      drive_wave(8, 8, 5);
      repeat (8) tick();
      check("sq16_valids", 64'(valid_cnt - v0), 64'd5);
      check("sq16_period", 64'(seen_period), 64'd16);

      // Timeout after signal stops low; period_out holds
      drive_wave(5, 5, 2);
      repeat (120) tick();
      check("to_timeout", 64'(timeout), 64'd1);
      check("to_locked", 64'(locked), 64'd0);
      check("to_period_hold", 64'(period_out), 64'd10);
      v0 = valid_cnt;
      drive_wave(5, 5, 1);
      repeat (8) tick();
      check("rearm_timeout", 64'(timeout), 64'd0);
      check("rearm_no_valid", 64'(valid_cnt - v0), 64'd0);

      // Reset between two rises: next rise only arms
      drive_wave(5, 5, 1);
      sig_in = 1'b1;
      repeat (5) tick();
      sig_in = 1'b0;
      repeat (2) tick();
      reset_pulse();
      repeat (3) tick();
      v0 = valid_cnt;
      drive_wave(5, 5, 2);
      repeat (8) tick();
      check("post_rst_valids", 64'(valid_cnt - v0), 64'd1);
      check("post_rst_period", 64'(seen_period), 64'd10);

      // Period exactly TIMEOUT: rise wins
      drive_wave(1, 99, 3);
      check("p100_period", 64'(seen_period), 64'd100);
      check("p100_no_timeout", 64'(timeout), 64'd0);
      // Period TIMEOUT+1: times out
      drive_wave(1, 100, 2);
      repeat (5) tick();
      check("p101_timeout", 64'(timeout), 64'd1);
      check("p101_period_hold", 64'(seen_period), 64'd100);

`ifdef PERIOD_METER_DUTY_EN
      drive_wave(3, 7, 4);
      repeat (8) tick();
      check("duty_period", 64'(seen_period), 64'd10);
      check("duty_high", 64'(seen_high), 64'd3);
`endif

      // Randomised segments
      for (int s = 0; s < 60; s++) begin
         int kind;
         kind = int'($urandom_range(0, 9));
         case (kind)
            0: begin
               sig_in = 1'b0;
               repeat (int'($urandom_range(95, 130))) tick();
            end
            1: begin
               repeat (int'($urandom_range(0, 4))) tick();
               reset_pulse();
            end
            2: drive_wave(1, int'($urandom_range(97, 101)), 2);
            default: drive_wave(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                                int'($urandom_range(1, 5)));
         endcase
      end
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
